// File: rtl/spi_transaction_sequencer_pkg.sv
// Shared types, error-bit positions and the read-detection helper for the
// SPI transaction sequencer.
package spi_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } seq_state_t;

    localparam int ERR_BAD_LEN    = 0;
    localparam int ERR_UNEXP_READ = 1;

    // Widest transaction the helper below understands; callers pad unused
    // mask bits with 1 (write) so they never look like reads.
    localparam int SEQ_MAX_WIDTH = 64;

    function automatic logic expects_read(input logic [SEQ_MAX_WIDTH-1:0] rw_mask,
                                          input int unsigned length);
        logic r;
        r = 1'b0;
        for (int unsigned i = 0; i < SEQ_MAX_WIDTH; i++) begin
            if (i < length && !rw_mask[i]) r = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_transaction_sequencer_if.sv
// Command, strobe, read-return and response bundle between the fabric,
// the sequencer and the downstream SPI core.
interface spi_seq_if #(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 6,
    parameter int MAX_OUTSTANDING       = 4
);
    localparam int RPW = $clog2(MAX_OUTSTANDING) + 1;

    // Handshakes: a word moves on a cycle where valid && ready are both high;
    // valid and its payload stay stable until that cycle, and ready may be
    // asserted without valid. spi_read_valid is a pulse with no back-pressure.
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [TRANSACTION_LEN_WIDTH-1:0] cmd_length;
    logic [DATA_WIDTH-1:0]            cmd_data;
    logic [DATA_WIDTH-1:0]            cmd_rw_mask;
    logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length;
    logic [DATA_WIDTH-1:0]            transaction_data;
    logic [DATA_WIDTH-1:0]            transaction_rw_mask;
    logic                             spi_read_valid;
    logic [DATA_WIDTH-1:0]            spi_read_data;
    logic                             rsp_valid;
    logic                             rsp_ready;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic [RPW-1:0]                   reads_pending;
    logic                             busy;
    logic [1:0]                       err;
    logic                             err_clear;

    modport slave (
        input  cmd_valid, cmd_length, cmd_data, cmd_rw_mask,
        input  spi_read_valid, spi_read_data, rsp_ready, err_clear,
        output cmd_ready, transaction_length, transaction_data, transaction_rw_mask,
        output rsp_valid, rsp_data, reads_pending, busy, err
    );

    modport master (
        output cmd_valid, cmd_length, cmd_data, cmd_rw_mask,
        output spi_read_valid, spi_read_data, rsp_ready, err_clear,
        input  cmd_ready, transaction_length, transaction_data, transaction_rw_mask,
        input  rsp_valid, rsp_data, reads_pending, busy, err
    );

endinterface

// File: rtl/spi_transaction_sequencer_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata shows the head entry
// whenever empty is low. Pushes when full and pops when empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wdata,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Queues SPI commands, issues one length strobe per command with enforced
// spacing, reserves read credits and buffers returned read words.
module spi_transaction_sequencer
    import spi_seq_pkg::*;
#(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 6,
    parameter int CMD_DEPTH             = 8,
    parameter int MAX_OUTSTANDING       = 4,
    parameter int ISSUE_GAP             = 4
) (
    input  logic       fabric_clk,
    input  logic       reset,
    spi_seq_if.slave   bus,
    output seq_state_t state_dbg
);
    localparam int          LW      = TRANSACTION_LEN_WIDTH;
    localparam int          DW      = DATA_WIDTH;
    localparam int          CMD_W   = LW + 2 * DW + 1;
    localparam int          CCW     = $clog2(CMD_DEPTH) + 1;
    localparam int          RPW     = $clog2(MAX_OUTSTANDING) + 1;
    localparam int          GW      = $clog2(ISSUE_GAP);
    localparam int unsigned MAX_LEN = DATA_WIDTH;

    seq_state_t state, state_n;
    logic [GW-1:0] gap_cnt, gap_n;

    logic             cmd_push, cmd_pop, cmd_full, cmd_empty;
    logic [CCW-1:0]   cmd_count;
    logic [CMD_W-1:0] cmd_wdata, cmd_rdata;
    logic [SEQ_MAX_WIDTH-1:0] mask_ext;
    logic             push_exp;

    logic [LW-1:0] head_len;
    logic [DW-1:0] head_mask, head_data;
    logic          head_exp, head_len_bad;

    logic          issue, bad_len;
    logic [LW-1:0] len_q;
    logic [DW-1:0] data_q, mask_q;
    logic [RPW-1:0] reads_pending;
    logic [1:0]    err_q, err_n;

    logic           rsp_push, rsp_pop, rsp_full, rsp_empty, in_flight, unexp_read;
    logic [RPW-1:0] rsp_count;
    logic           credit_take, credit_release;

    // Mask bits past DATA_WIDTH read as writes so they never fake a read.
    always_comb begin
        mask_ext             = '1;
        mask_ext[DW-1:0]     = bus.cmd_rw_mask;
    end

    assign push_exp  = expects_read(mask_ext, 32'(bus.cmd_length));
    assign cmd_push  = bus.cmd_valid && !cmd_full;
    assign cmd_wdata = {bus.cmd_length, bus.cmd_rw_mask, bus.cmd_data, push_exp};

    sync_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk   (fabric_clk),
        .reset (reset),
        .push  (cmd_push),
        .wdata (cmd_wdata),
        .pop   (cmd_pop),
        .rdata (cmd_rdata),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    assign head_len     = cmd_rdata[CMD_W-1 -: LW];
    assign head_mask    = cmd_rdata[2*DW : DW+1];
    assign head_data    = cmd_rdata[DW:1];
    assign head_exp     = cmd_rdata[0];
    assign head_len_bad = (head_len == '0) || (32'(head_len) > MAX_LEN);

    always_comb begin
        state_n = state;
        gap_n   = gap_cnt;
        cmd_pop = 1'b0;
        issue   = 1'b0;
        bad_len = 1'b0;
        case (state)
            S_IDLE: begin
                if (!cmd_empty) begin
                    if (head_len_bad) begin
                        cmd_pop = 1'b1;
                        bad_len = 1'b1;
                    end else if (!head_exp || reads_pending < RPW'(MAX_OUTSTANDING)) begin
                        cmd_pop = 1'b1;
                        issue   = 1'b1;
                        state_n = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                state_n = S_GAP;
                gap_n   = GW'(ISSUE_GAP - 2);
            end
            S_GAP: begin
                // Leaving on the last gap cycle lets IDLE pop in the cycle
                // before the next strobe, keeping strobes ISSUE_GAP apart.
                gap_n   = gap_cnt - GW'(1);
                state_n = (gap_cnt <= GW'(1)) ? S_IDLE : S_GAP;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Credits reserved beyond the words already buffered are reads still owed
    // by the core; rsp_full implies none are owed.
    assign in_flight      = (reads_pending > rsp_count) && !rsp_full;
    assign rsp_push       = bus.spi_read_valid && in_flight;
    assign unexp_read     = bus.spi_read_valid && !in_flight;
    assign rsp_pop        = bus.rsp_ready && !rsp_empty;
    assign credit_take    = issue && head_exp;
    assign credit_release = rsp_pop;

    sync_fifo #(.WIDTH(DW), .DEPTH(MAX_OUTSTANDING)) u_rsp_fifo (
        .clk   (fabric_clk),
        .reset (reset),
        .push  (rsp_push),
        .wdata (bus.spi_read_data),
        .pop   (rsp_pop),
        .rdata (bus.rsp_data),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    always_comb begin
        err_n = err_q;
        if (bus.err_clear) err_n = '0;
        if (bad_len)       err_n[ERR_BAD_LEN]    = 1'b1;
        if (unexp_read)    err_n[ERR_UNEXP_READ] = 1'b1;
    end

    always_ff @(posedge fabric_clk) begin
        if (reset) begin
            state         <= S_IDLE;
            gap_cnt       <= '0;
            len_q         <= '0;
            data_q        <= '0;
            mask_q        <= '0;
            reads_pending <= '0;
            err_q         <= '0;
        end else begin
            state   <= state_n;
            gap_cnt <= gap_n;
            err_q   <= err_n;
            if (issue) begin
                len_q  <= head_len;
                data_q <= head_data;
                mask_q <= head_mask;
            end
            case ({credit_take, credit_release})
                2'b10:   reads_pending <= reads_pending + RPW'(1);
                2'b01:   reads_pending <= reads_pending - RPW'(1);
                default: reads_pending <= reads_pending;
            endcase
        end
    end

    assign bus.cmd_ready           = !cmd_full;
    assign bus.transaction_length  = (state == S_ISSUE) ? len_q : '0;
    assign bus.transaction_data    = data_q;
    assign bus.transaction_rw_mask = mask_q;
    assign bus.rsp_valid           = !rsp_empty;
    assign bus.reads_pending       = reads_pending;
    assign bus.err                 = err_q;
    assign bus.busy                = (cmd_count != '0) || (state != S_IDLE) || (reads_pending != '0);
    assign state_dbg               = state;

endmodule
